child_genome_assembler: RTL and testbench

CHILD_GENOME_ASSEMBLER -- requirements
Module: child_genome_assembler

---
 rtl/neat_xover_pkg.sv | 27 ++
 rtl/xover_wr_stage.sv | 52 +++++
 rtl/child_genome_assembler.sv | 169 ++++++++++++++++
 tb/tb_child_genome_assembler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neat_xover_pkg.sv
// neat_xover_pkg: shared definitions for the child genome assembler.
//   - SEL_* : crossover select codes from the upstream selector stage
//   - SRC_* : which parent a pending child write is sourced from
//   - state_t : assembler FSM state encoding
package neat_xover_pkg;

  localparam logic [1:0] SEL_NOP = 2'b00;
  localparam logic [1:0] SEL_END = 2'b01;
  localparam logic [1:0] SEL_P1  = 2'b10;
  localparam logic [1:0] SEL_P2  = 2'b11;

  localparam logic SRC_P1 = 1'b0;
  localparam logic SRC_P2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Codes 10 and 11 carry a gene; the MSB alone identifies them.
  function automatic logic sel_is_gene(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/xover_wr_stage.sv
// xover_wr_stage: one-cycle pending-write register. A gene accepted in one
// cycle is written to the child RAM in the next, when the parent RAM read
// data for that gene has arrived.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset (drops any pending write)
//   load           : capture a new pending write this cycle
//   load_src       : parent source of the write (SRC_P1 / SRC_P2)
//   load_addr      : child address of the write
//   pend_valid     : a write is pending this cycle
//   pend_src       : parent source of the pending write
//   pend_addr      : child address of the pending write
module xover_wr_stage
  import neat_xover_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_src,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              pend_valid,
  output logic              pend_src,
  output logic [ADDR_W-1:0] pend_addr
);

  logic              valid_r;
  logic              src_r;
  logic [ADDR_W-1:0] addr_r;

  // Pending-write register: valid for exactly the cycle after a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      src_r   <= SRC_P1;
      addr_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      src_r   <= load_src;
      addr_r  <= load_addr;
    end else begin
      valid_r <= 1'b0;
      src_r   <= src_r;
      addr_r  <= addr_r;
    end
  end

  assign pend_valid = valid_r;
  assign pend_src   = src_r;
  assign pend_addr  = addr_r;

endmodule

// File: rtl/child_genome_assembler.sv
// child_genome_assembler: builds a child genome by copying genes from two
// parent gene RAMs as directed by a stream of crossover select codes.
// Optional feature macro: XOVER_STATS_EN (adds p1_count / p2_count outputs).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start                    : begin a new child (sampled in IDLE only)
//   sel, sel_valid, sel_ready: crossover select handshake (ready in RUN only)
//   gene1_addr, gene2_addr   : parent RAM read addresses (= parent pointers)
//   gene1_data, gene2_data   : parent RAM read data, one cycle after address
//   child_wr_en/addr/data    : child RAM write port
//   child_size               : genes written, valid in DONE, held until next start
//   done                     : one-cycle completion pulse
//   overflow                 : sticky, a gene was dropped at capacity
//   p1_count, p2_count       : (XOVER_STATS_EN) genes written from each parent
module child_genome_assembler
  import neat_xover_pkg::*;
#(
  parameter int GENE_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_GENES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        sel,
  input  logic              sel_valid,
  output logic              sel_ready,
  output logic [ADDR_W-1:0] gene1_addr,
  output logic [ADDR_W-1:0] gene2_addr,
  input  logic [GENE_W-1:0] gene1_data,
  input  logic [GENE_W-1:0] gene2_data,
  output logic              child_wr_en,
  output logic [ADDR_W-1:0] child_addr,
  output logic [GENE_W-1:0] child_data,
  output logic [ADDR_W-1:0] child_size,
  output logic              done,
  output logic              overflow
`ifdef XOVER_STATS_EN
  ,
  output logic [ADDR_W-1:0] p1_count,
  output logic [ADDR_W-1:0] p2_count
`endif
);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] p1_ptr_r, p2_ptr_r, wr_ptr_r, child_size_r;
  logic [ADDR_W-1:0] fill_s;
  logic              overflow_r;
  logic              start_acc_s, hs_s, gene_acc_s, full_s, load_s, load_src_s;
  logic              pend_valid_s, pend_src_s;
  logic [ADDR_W-1:0] pend_addr_s;

  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign hs_s        = (state_r == ST_RUN) && sel_valid;
  assign gene_acc_s  = hs_s && sel_is_gene(sel);
  // Occupancy counts the write still in flight so capacity is never exceeded.
  assign fill_s      = wr_ptr_r + {{(ADDR_W-1){1'b0}}, pend_valid_s};
  assign full_s      = (fill_s == ADDR_W'(MAX_GENES));
  assign load_s      = gene_acc_s && !full_s;
  assign load_src_s  = (sel == SEL_P2) ? SRC_P2 : SRC_P1;

  xover_wr_stage #(.ADDR_W(ADDR_W)) u_wr_stage (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_src   (load_src_s),
    .load_addr  (fill_s),
    .pend_valid (pend_valid_s),
    .pend_src   (pend_src_s),
    .pend_addr  (pend_addr_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_acc_s) state_nxt_s = ST_RUN; else state_nxt_s = ST_IDLE;
      ST_RUN:   if (hs_s && (sel == SEL_END)) state_nxt_s = ST_FLUSH; else state_nxt_s = ST_RUN;
      ST_FLUSH: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Parent/child pointers, overflow flag and latched child size.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_ptr_r     <= '0;
      p2_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      overflow_r   <= 1'b0;
      child_size_r <= '0;
    end else if (start_acc_s) begin
      p1_ptr_r     <= '0;
      p2_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      overflow_r   <= 1'b0;
      child_size_r <= '0;
    end else begin
      // Parent pointers advance on every accepted gene, even when dropped.
      if (gene_acc_s && (sel == SEL_P1)) p1_ptr_r <= p1_ptr_r + 1'b1;
      else                               p1_ptr_r <= p1_ptr_r;
      if (gene_acc_s && (sel == SEL_P2)) p2_ptr_r <= p2_ptr_r + 1'b1;
      else                               p2_ptr_r <= p2_ptr_r;
      if (pend_valid_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      else              wr_ptr_r <= wr_ptr_r;
      if (gene_acc_s && full_s) overflow_r <= 1'b1;
      else                      overflow_r <= overflow_r;
      // fill_s in FLUSH already includes the final in-flight write.
      if (state_r == ST_FLUSH) child_size_r <= fill_s;
      else                     child_size_r <= child_size_r;
    end
  end

  // Child write data comes straight from the RAM read port of the chosen parent.
  always_comb begin
    child_data = gene1_data;
    if (pend_src_s == SRC_P2) child_data = gene2_data;
    else                      child_data = gene1_data;
  end

  assign sel_ready   = (state_r == ST_RUN);
  assign done        = (state_r == ST_DONE);
  assign gene1_addr  = p1_ptr_r;
  assign gene2_addr  = p2_ptr_r;
  assign child_wr_en = pend_valid_s;
  assign child_addr  = pend_addr_s;
  assign child_size  = child_size_r;
  assign overflow    = overflow_r;

`ifdef XOVER_STATS_EN
  logic [ADDR_W-1:0] p1_cnt_r, p2_cnt_r;

  // Per-parent counts of genes actually written to the child.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_cnt_r <= '0;
      p2_cnt_r <= '0;
    end else if (start_acc_s) begin
      p1_cnt_r <= '0;
      p2_cnt_r <= '0;
    end else if (pend_valid_s) begin
      if (pend_src_s == SRC_P2) begin
        p1_cnt_r <= p1_cnt_r;
        p2_cnt_r <= p2_cnt_r + 1'b1;
      end else begin
        p1_cnt_r <= p1_cnt_r + 1'b1;
        p2_cnt_r <= p2_cnt_r;
      end
    end else begin
      p1_cnt_r <= p1_cnt_r;
      p2_cnt_r <= p2_cnt_r;
    end
  end

  assign p1_count = p1_cnt_r;
  assign p2_count = p2_cnt_r;
`endif

endmodule

// File: tb/tb_child_genome_assembler.sv
// tb_child_genome_assembler: self-checking bench for child_genome_assembler.
// A small parent-RAM model feeds the DUT; expected child writes (address,
// data, cycle), final pointers, size and overflow come from a queue-based
// model of the crossover rules. Build with XOVER_STATS_EN to also check
// p1_count / p2_count.
module tb_child_genome_assembler;

  localparam int GENE_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int MAX_GENES = 4;
  localparam int PTR_MOD   = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [GENE_W-1:0] data;
    logic [31:0]       wcyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        sel = 2'b00;
  logic              sel_valid = 1'b0;
  logic              sel_ready;
  logic [ADDR_W-1:0] gene1_addr, gene2_addr;
  logic [GENE_W-1:0] gene1_data = '0;
  logic [GENE_W-1:0] gene2_data = '0;
  logic              child_wr_en;
  logic [ADDR_W-1:0] child_addr;
  logic [GENE_W-1:0] child_data;
  logic [ADDR_W-1:0] child_size;
  logic              done;
  logic              overflow;
`ifdef XOVER_STATS_EN
  logic [ADDR_W-1:0] p1_count, p2_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t        obs_q[$];
  logic [1:0] item_sel[$];
  logic       item_vld[$];
  logic       item_start[$];

  child_genome_assembler #(
    .GENE_W(GENE_W), .ADDR_W(ADDR_W), .MAX_GENES(MAX_GENES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .gene1_addr(gene1_addr), .gene2_addr(gene2_addr),
    .gene1_data(gene1_data), .gene2_data(gene2_data),
    .child_wr_en(child_wr_en), .child_addr(child_addr), .child_data(child_data),
    .child_size(child_size), .done(done), .overflow(overflow)
`ifdef XOVER_STATS_EN
    , .p1_count(p1_count), .p2_count(p2_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [GENE_W-1:0] p1_gene(input logic [ADDR_W-1:0] a);
    return 32'hA1C0_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  function automatic logic [GENE_W-1:0] p2_gene(input logic [ADDR_W-1:0] a);
    return 32'h5B20_0000 ^ (32'(a) * 32'h0302_0100) ^ 32'h0000_00F0;
  endfunction

  // Parent RAMs: synchronous read, data one cycle after address.
  always @(posedge clk) begin
    gene1_data <= p1_gene(gene1_addr);
    gene2_data <= p2_gene(gene2_addr);
  end

  // Write monitor.
  always @(negedge clk) begin
    if (child_wr_en === 1'b1) obs_q.push_back({child_addr, child_data, 32'(cyc)});
  end

  task automatic clear_items();
    item_sel.delete(); item_vld.delete(); item_start.delete();
  endtask

  task automatic add_item(input logic [1:0] s, input logic v, input logic st);
    item_sel.push_back(s); item_vld.push_back(v); item_start.push_back(st);
  endtask

  // Runs one child from start through DONE and checks it against the model.
  task automatic run_seq(input string name);
    wr_t exp_q[$];
    wr_t w;
    int  p1, p2, cnt, n1, n2;
    logic ovf;
    p1 = 0; p2 = 0; cnt = 0; n1 = 0; n2 = 0; ovf = 1'b0;
    obs_q.delete();
    @(posedge clk); #1; start = 1'b1; sel_valid = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < item_sel.size(); i++) begin
      sel = item_sel[i]; sel_valid = item_vld[i]; start = item_start[i];
      if (item_vld[i] && item_sel[i][1]) begin
        if (cnt < MAX_GENES) begin
          w.addr = ADDR_W'(cnt);
          w.data = item_sel[i][0] ? p2_gene(ADDR_W'(p2)) : p1_gene(ADDR_W'(p1));
          w.wcyc = 32'(cyc + 1);
          exp_q.push_back(w);
          cnt++;
          if (item_sel[i][0]) n2++; else n1++;
        end else begin
          ovf = 1'b1;
        end
        if (item_sel[i][0]) p2 = (p2 + 1) % PTR_MOD; else p1 = (p1 + 1) % PTR_MOD;
      end
      @(posedge clk); #1;
    end
    sel_valid = 1'b0; sel = 2'b00; start = 1'b0;
    // FLUSH cycle
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s flush_done got=%b want=0", name, done); end
    total++; if (sel_ready !== 1'b0) begin bad++; $display("FAIL %s flush_ready got=%b want=0", name, sel_ready); end
    // DONE cycle
    @(posedge clk); #1; @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done got=%b want=1", name, done); end
    total++; if (child_size !== ADDR_W'(cnt)) begin bad++; $display("FAIL %s child_size got=%0d want=%0d", name, child_size, cnt); end
    total++; if (overflow !== ovf) begin bad++; $display("FAIL %s overflow got=%b want=%b", name, overflow, ovf); end
    total++; if (gene1_addr !== ADDR_W'(p1)) begin bad++; $display("FAIL %s p1_ptr got=%0d want=%0d", name, gene1_addr, p1); end
    total++; if (gene2_addr !== ADDR_W'(p2)) begin bad++; $display("FAIL %s p2_ptr got=%0d want=%0d", name, gene2_addr, p2); end
`ifdef XOVER_STATS_EN
    total++; if (p1_count !== ADDR_W'(n1)) begin bad++; $display("FAIL %s p1_count got=%0d want=%0d", name, p1_count, n1); end
    total++; if (p2_count !== ADDR_W'(n2)) begin bad++; $display("FAIL %s p2_count got=%0d want=%0d", name, p2_count, n2); end
`endif
    // back in IDLE
    @(negedge clk);
    total++; if (done !== 1'b0 || sel_ready !== 1'b0) begin bad++; $display("FAIL %s post_done done=%b ready=%b want 0/0", name, done, sel_ready); end
    repeat (2) @(negedge clk);
    total++; if (child_size !== ADDR_W'(cnt)) begin bad++; $display("FAIL %s size_hold got=%0d want=%0d", name, child_size, cnt); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s write_count got=%0d want=%0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].wcyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].wcyc);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (sel_ready !== 1'b0 || child_wr_en !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
        child_size !== '0 || gene1_addr !== '0 || gene2_addr !== '0) begin
      bad++;
      $display("FAIL %s rdy=%b wr=%b done=%b ovf=%b size=%0d a1=%0d a2=%0d want all 0",
               name, sel_ready, child_wr_en, done, overflow, child_size, gene1_addr, gene2_addr);
    end
`ifdef XOVER_STATS_EN
    total++;
    if (p1_count !== '0 || p2_count !== '0) begin
      bad++; $display("FAIL %s counts p1=%0d p2=%0d want 0", name, p1_count, p2_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_basic();
    clear_items();
    add_item(2'b10, 1'b1, 1'b0); add_item(2'b11, 1'b1, 1'b0);
    add_item(2'b10, 1'b1, 1'b0); add_item(2'b01, 1'b1, 1'b0);
    run_seq("basic");
    // stats scenario: 10,10,11,01
    clear_items();
    add_item(2'b10, 1'b1, 1'b0); add_item(2'b10, 1'b1, 1'b0);
    add_item(2'b11, 1'b1, 1'b0); add_item(2'b01, 1'b1, 1'b0);
    run_seq("stats");
  endtask

  task automatic test_valid_gaps();
    clear_items();
    add_item(2'b10, 1'b1, 1'b0); add_item(2'b10, 1'b0, 1'b0);
    add_item(2'b10, 1'b1, 1'b0); add_item(2'b00, 1'b1, 1'b0);
    add_item(2'b01, 1'b0, 1'b0); add_item(2'b01, 1'b1, 1'b0);
    run_seq("valid_gaps");
  endtask

  task automatic test_overflow();
    clear_items();
    for (int i = 0; i < 6; i++) add_item(2'b11, 1'b1, 1'b0);
    add_item(2'b01, 1'b1, 1'b0);
    run_seq("overflow_p2");
    clear_items();
    for (int i = 0; i < 18; i++) add_item(2'b10, 1'b1, 1'b0);
    add_item(2'b01, 1'b1, 1'b0);
    run_seq("overflow_wrap");
    clear_items();
    for (int i = 0; i < 4; i++) add_item(2'b10, 1'b1, 1'b0);
    add_item(2'b01, 1'b1, 1'b0);
    run_seq("exact_capacity");
  endtask

  task automatic test_start_ignored();
    clear_items();
    add_item(2'b10, 1'b1, 1'b1); add_item(2'b00, 1'b0, 1'b1);
    add_item(2'b11, 1'b1, 1'b1); add_item(2'b01, 1'b1, 1'b1);
    run_seq("start_ignored");
  endtask

  task automatic test_reset_mid_run();
    int n_before;
    obs_q.delete();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; sel = 2'b10; sel_valid = 1'b1;
    @(posedge clk); #1; sel = 2'b10; sel_valid = 1'b1;
    @(posedge clk); #1; sel_valid = 1'b0; sel = 2'b00; rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_run_reset");
    n_before = obs_q.size();
    repeat (2) @(negedge clk);
    total++;
    if (obs_q.size() != 1 || n_before != 1) begin
      bad++; $display("FAIL mid_run_writes got=%0d/%0d want=1", n_before, obs_q.size());
    end
    @(posedge clk); #1; rst = 1'b1;
    clear_items();
    add_item(2'b11, 1'b1, 1'b0); add_item(2'b10, 1'b1, 1'b0); add_item(2'b01, 1'b1, 1'b0);
    run_seq("after_reset");
  endtask

  task automatic test_random();
    int len;
    logic [1:0] c;
    for (int t = 0; t < 40; t++) begin
      clear_items();
      len = $urandom_range(0, 20);
      for (int i = 0; i < len; i++) begin
        c = 2'($urandom_range(0, 3));
        if (c == 2'b01) add_item(c, 1'b0, 1'($urandom_range(0, 1)));
        else add_item(c, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      add_item(2'b01, 1'b1, 1'b0);
      run_seq($sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_gaps();
    test_overflow();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
